// File: rtl/pixel_writer.sv
// pixel_writer: receive-side raster writer for the coprocessor output frame buffer.
// Accepts a valid/ready pixel stream, tracks (x, y) and a linear address, and
// issues one registered RAM write per accepted pixel. Pulses frame_done once the
// last write of an IMG_WIDTH x IMG_HEIGHT frame has gone out.
// Optional feature: define PIXEL_WRITER_CHECKSUM_EN to build a 16-bit running
// sum of accepted pixels on the checksum port.
module pixel_writer #(
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4,
    parameter int PIXEL_W    = 8,
    parameter int ADDR_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pixel_valid,
    input  logic [PIXEL_W-1:0] pixel_in,
    output logic               pixel_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PIXEL_W-1:0] wr_data,
    output logic [3:0]         x_out,
    output logic [3:0]         y_out,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow
`ifdef PIXEL_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]        checksum
`endif
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              last_pixel;
    logic              start_accept;

    // State register; reset always lands in IDLE, even if start is also high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus decodes of the current state (ready, busy, accept).
    always_comb begin
        next_state   = state;
        pixel_ready  = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;
        last_pixel   = 1'b0;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    next_state   = RECV;
                end
            end
            RECV: begin
                pixel_ready = 1'b1;
                busy        = 1'b1;
                if (pixel_valid) begin
                    accept = 1'b1;
                    if (x == X_LAST && y == Y_LAST) begin
                        last_pixel = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Raster position and linear address advance together so no multiply is needed.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (accept) begin
            if (last_pixel) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else if (x == X_LAST) begin
                x    <= '0;
                y    <= y + YW'(1);
                addr <= addr + ADDR_W'(1);
            end else begin
                x    <= x + XW'(1);
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    // Registered write port: one strobe per accepted pixel, address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= addr;
                wr_data <= pixel_in;
            end
        end
    end

    // frame_done fires on leaving DONE, i.e. one cycle after the last write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DONE);
        end
    end

    // Sticky flag for pixels offered while not accepting; a new frame clears it.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            overflow <= 1'b0;
        end else if (pixel_valid && state != RECV) begin
            overflow <= 1'b1;
        end
    end

`ifdef PIXEL_WRITER_CHECKSUM_EN
    // Running modulo-2^16 sum of accepted pixels, restarted with each frame.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + 16'(pixel_in);
        end
    end
`else
`endif

    assign x_out = 4'(x);
    assign y_out = 4'(y);

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: scoreboard bench for pixel_writer (4x4 frame, 8-bit pixels).
// Expected writes are queued as pixels are driven and popped as wr_en appears.
module tb_pixel_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pixel_valid;
    logic [7:0] pixel_in;
    logic       pixel_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] x_out;
    logic [3:0] y_out;
    logic       busy;
    logic       frame_done;
    logic       overflow;
`ifdef PIXEL_WRITER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_item;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          fd_count     = 0;
    logic [15:0] exp_sum      = '0;

    pixel_writer #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(4),
        .PIXEL_W   (8),
        .ADDR_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pixel_valid(pixel_valid),
        .pixel_in   (pixel_in),
        .pixel_ready(pixel_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .x_out      (x_out),
        .y_out      (y_out),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef PIXEL_WRITER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_wr_en", 32'(wr_en), 32'd0);
            end else begin
                mon_item = exp_q.pop_front();
                checkOutput("wr_addr", 32'(wr_addr), 32'(mon_item.addr));
                checkOutput("wr_data", 32'(wr_data), 32'(mon_item.data));
            end
        end
        if (frame_done === 1'b1) begin
            fd_count++;
`ifdef PIXEL_WRITER_CHECKSUM_EN
            checkOutput("checksum_at_done", 32'(checksum), 32'(exp_sum));
`endif
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pixel_ready"}, 32'(pixel_ready), 32'd0);
        checkOutput({tag, "_wr_en"},       32'(wr_en),       32'd0);
        checkOutput({tag, "_wr_addr"},     32'(wr_addr),     32'd0);
        checkOutput({tag, "_wr_data"},     32'(wr_data),     32'd0);
        checkOutput({tag, "_x_out"},       32'(x_out),       32'd0);
        checkOutput({tag, "_y_out"},       32'(y_out),       32'd0);
        checkOutput({tag, "_busy"},        32'(busy),        32'd0);
        checkOutput({tag, "_frame_done"},  32'(frame_done),  32'd0);
        checkOutput({tag, "_overflow"},    32'(overflow),    32'd0);
`ifdef PIXEL_WRITER_CHECKSUM_EN
        checkOutput({tag, "_checksum"},    32'(checksum),    32'd0);
`endif
    endtask

    task automatic startFrame();
        start = 1'b1;
        nextCycle();
        start   = 1'b0;
        exp_sum = '0;
        checkOutput("ready_after_start",    32'(pixel_ready), 32'd1);
        checkOutput("busy_after_start",     32'(busy),        32'd1);
        checkOutput("overflow_after_start", 32'(overflow),    32'd0);
    endtask

    // Drive count pixels starting at raster 0; gap idle cycles between pixels;
    // start is also pulsed alongside pixel start_at (-1 for never).
    task automatic applyStimulus(input int count, input int gap, input bit fixed,
                                 input logic [7:0] value, input int start_at);
        wr_t item;
        for (int k = 0; k < count; k++) begin
            checkOutput("x_out", 32'(x_out), 32'(k % 4));
            checkOutput("y_out", 32'(y_out), 32'(k / 4));
            pixel_valid = 1'b1;
            pixel_in    = fixed ? value : 8'(k);
            start       = (k == start_at);
            item.addr   = 4'(k);
            item.data   = pixel_in;
            exp_q.push_back(item);
            exp_sum     = exp_sum + 16'(pixel_in);
            nextCycle();
            pixel_valid = 1'b0;
            start       = 1'b0;
            if (k != count - 1) begin
                for (int g = 0; g < gap; g++) nextCycle();
            end
        end
    endtask

    // Called right after the last accept edge: DONE cycle, then frame_done cycle
    task automatic finishFrame(input string tag);
        int fd_before;
        fd_before = fd_count;
        checkOutput({tag, "_ready_in_done"}, 32'(pixel_ready), 32'd0);
        checkOutput({tag, "_busy_in_done"},  32'(busy),        32'd1);
        nextCycle();
        checkOutput({tag, "_frame_done"},    32'(frame_done),  32'd1);
        checkOutput({tag, "_busy_idle"},     32'(busy),        32'd0);
        nextCycle();
        checkOutput({tag, "_frame_done_low"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_done_pulses"},    32'(fd_count - fd_before), 32'd1);
        checkOutput({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        checkOutput({tag, "_x_wrapped"},      32'(x_out), 32'd0);
        checkOutput({tag, "_y_wrapped"},      32'(y_out), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = '0;
        nextCycle();
        nextCycle();
        checkResetState("reset");
        reset = 1'b0;
        nextCycle();

        // Back-to-back frame of 0x00..0x0F
        startFrame();
        applyStimulus(16, 0, 1'b0, 8'h00, -1);
        finishFrame("b2b");

        // Same frame with valid low every other cycle
        startFrame();
        applyStimulus(16, 1, 1'b0, 8'h00, -1);
        finishFrame("gap");

        // Pixel offered in IDLE sets overflow, writes nothing; start clears it
        pixel_valid = 1'b1;
        pixel_in    = 8'hAA;
        nextCycle();
        pixel_valid = 1'b0;
        checkOutput("overflow_set", 32'(overflow), 32'd1);
        nextCycle();
        checkOutput("overflow_sticky", 32'(overflow), 32'd1);
        checkOutput("no_wr_in_idle",   32'(wr_en),    32'd0);
        startFrame();
        applyStimulus(16, 0, 1'b0, 8'h00, -1);
        finishFrame("after_ovf");

        // start pulsed mid-frame is ignored
        startFrame();
        applyStimulus(16, 0, 1'b0, 8'h00, 5);
        finishFrame("mid_start");
        checkOutput("mid_start_no_ovf", 32'(overflow), 32'd0);

        // Reset after 7 pixels abandons the frame
        startFrame();
        applyStimulus(7, 0, 1'b0, 8'h00, -1);
        reset = 1'b1;
        nextCycle();
        checkResetState("mid_reset");
        reset = 1'b0;
        checkOutput("mid_reset_pending", 32'(exp_q.size()), 32'd0);
        nextCycle();
        nextCycle();

        // reset wins over a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        nextCycle();
        reset = 1'b0;
        start = 1'b0;
        checkOutput("reset_start_busy",  32'(busy),        32'd0);
        checkOutput("reset_start_ready", 32'(pixel_ready), 32'd0);
        nextCycle();

        startFrame();
        applyStimulus(16, 0, 1'b0, 8'h00, -1);
        finishFrame("after_reset");

        // Constant-pixel frames (exercise the checksum when built)
        startFrame();
        applyStimulus(16, 0, 1'b1, 8'hFF, -1);
        finishFrame("ff_frame");
`ifdef PIXEL_WRITER_CHECKSUM_EN
        checkOutput("checksum_ff", 32'(checksum), 32'h0FF0);
`endif
        startFrame();
        applyStimulus(16, 0, 1'b1, 8'h01, -1);
        finishFrame("one_frame");
`ifdef PIXEL_WRITER_CHECKSUM_EN
        checkOutput("checksum_01", 32'(checksum), 32'h0010);
`endif

        nextCycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
